// File: rtl/jpc_fetch.sv
// Instruction fetch sequencer: one imem read per instruction, PC +4 on each ack, redirects from execute.
// Optional misaligned-redirect fault under JPC_FETCH_ALIGN_CHECK_EN; decode backpressure holds the current word.
`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module jpc_fetch #(
   parameter int ADDR_WIDTH  = `JPC_ADDRESS_WIDTH,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  pc_I,
   output logic [ADDR_WIDTH-1:0]  next_pc_O,
   output logic                   pc_en_O,
   output logic                   imem_req_O,
   output logic [ADDR_WIDTH-1:0]  imem_addr_O,
   input  logic                   imem_ack_I,
   input  logic [INSTR_WIDTH-1:0] imem_data_I,
   output logic                   instr_valid_O,
   output logic [INSTR_WIDTH-1:0] instr_O,
   output logic [ADDR_WIDTH-1:0]  instr_pc_O,
   input  logic                   instr_ready_I,
`ifdef JPC_FETCH_ALIGN_CHECK_EN
   output logic                   misalign_O,
`endif
   input  logic                   redirect_I,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc_I
);

`ifdef JPC_FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN, S_FAULT} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;
`endif

   state_t                 r_state;
   logic                   r_req;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic                   r_valid;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [ADDR_WIDTH-1:0]  r_instr_pc;

   logic                   w_redir;
   state_t                 w_rest;

`ifdef JPC_FETCH_ALIGN_CHECK_EN
   logic r_misalign;
   logic w_bad;

   // Once a fault is pending or taken, further redirects are ignored.
   assign w_bad      = (redirect_pc_I[1:0] != 2'b00);
   assign w_redir    = redirect_I && !r_misalign;
   assign w_rest     = (r_misalign || (w_redir && w_bad)) ? S_FAULT : S_IDLE;
   assign misalign_O = r_misalign;
`else
   assign w_redir = redirect_I;
   assign w_rest  = S_IDLE;
`endif

   always_comb begin
      pc_en_O   = 1'b0;
      next_pc_O = pc_I + ADDR_WIDTH'(4);
      if (w_redir) begin
         pc_en_O   = 1'b1;
         next_pc_O = redirect_pc_I;
      end else if (r_state == S_WAIT && imem_ack_I) begin
         pc_en_O = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
`ifdef JPC_FETCH_ALIGN_CHECK_EN
         r_misalign <= 1'b0;
`endif
      end else begin
`ifdef JPC_FETCH_ALIGN_CHECK_EN
         if (w_redir && w_bad)
            r_misalign <= 1'b1;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_redir) begin
                  r_state <= w_rest;
               end else begin
                  r_req   <= 1'b1;
                  r_addr  <= pc_I;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A redirect without ack leaves the request open; its response is drained.
               if (w_redir) begin
                  if (imem_ack_I) begin
                     r_req   <= 1'b0;
                     r_state <= w_rest;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else if (imem_ack_I) begin
                  r_instr    <= imem_data_I;
                  r_instr_pc <= r_addr;
                  r_valid    <= 1'b1;
                  r_req      <= 1'b0;
                  r_state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_redir) begin
                  r_valid <= 1'b0;
                  r_state <= w_rest;
               end else if (instr_ready_I) begin
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
                  r_addr  <= pc_I;
                  r_state <= S_WAIT;
               end
            end
            S_DRAIN: begin
               if (imem_ack_I) begin
                  r_req   <= 1'b0;
                  r_state <= w_rest;
               end
            end
            default: r_state <= w_rest;
         endcase
      end
   end

   assign imem_req_O    = r_req;
   assign imem_addr_O   = r_addr;
   assign instr_valid_O = r_valid;
   assign instr_O       = r_instr;
   assign instr_pc_O    = r_instr_pc;

endmodule
